// File: rtl/fifo_pkg.sv
// Shared FIFO word type, geometry and scheduler types used by the push scheduler
// and by anything that talks to the FIFO slave interface.
package fifo_pkg;

    localparam int DATA_W      = 8;
    localparam int BIT_DEPTH   = 4;
    localparam int ALMOST_FULL = 12;
    localparam int FIFO_DEPTH  = 2 ** BIT_DEPTH;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

    typedef logic [$clog2(FIFO_DEPTH+1)-1:0] credit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester found when scanning
// upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_push_scheduler.sv
// Shares one FIFO push port between NUM_REQ producers with round-robin arbitration,
// credit-based full protection, almost-full priority gating and a flush/drain handshake.
module fifo_push_scheduler
    import fifo_pkg::*;
#(
    parameter int                 NUM_REQ  = 4,
    parameter int                 DEPTH    = 2 ** BIT_DEPTH,
    parameter int                 AF_LEVEL = ALMOST_FULL,
    parameter logic [NUM_REQ-1:0] HP_MASK  = NUM_REQ'(1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  word_t [NUM_REQ-1:0]          req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         fifo_push,
    output word_t                        fifo_data_in,
    input  logic                         fifo_pop,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         hp_only,
    output logic                         credit_err
);

    localparam int             CW           = $clog2(DEPTH + 1);
    localparam int             IW           = $clog2(NUM_REQ);
    localparam logic [CW-1:0]  FULL_CREDITS = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_OCC       = CW'(AF_LEVEL);

    sched_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                fifo_push_q, fifo_push_d;
    word_t               data_q, data_d;
    logic                flush_done_q, flush_done_d;
    logic [CW-1:0]       credits_q, credits_d;
    logic                hp_only_q, hp_only_d;
    logic                credit_err_q, credit_err_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [IW-1:0]       grant_idx;
    logic                grant_any;
    logic                pop_eff;

    // A requester whose ack is on the outputs this cycle is masked so it cannot
    // be granted again before it has had a chance to present new data.
    always_comb begin
        eligible = req & ~ack_q;
        if (hp_only_q) begin
            eligible = eligible & HP_MASK;
        end
        if (state_q != RUN || flush || credits_q == '0) begin
            eligible = '0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_any)
    );

    always_comb begin
        pop_eff     = fifo_pop && !fifo_empty;
        ack_d       = grant_oh;
        fifo_push_d = grant_any;
        data_d      = grant_any ? req_data[grant_idx] : data_q;

        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // Grants only happen with credits > 0, so only the pop side needs clamping.
        credits_d = credits_q;
        if (pop_eff && !grant_any) begin
            if (credits_q != FULL_CREDITS) begin
                credits_d = credits_q + 1'b1;
            end
        end else if (grant_any && !pop_eff) begin
            credits_d = credits_q - 1'b1;
        end

        hp_only_d    = (FULL_CREDITS - credits_d) >= AF_OCC;
        credit_err_d = credit_err_q
                     | (fifo_push_q && fifo_full && !fifo_pop)
                     | (pop_eff && credits_q == FULL_CREDITS);
    end

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (credits_q == FULL_CREDITS && fifo_empty) begin
                    flush_done_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            ack_q        <= '0;
            fifo_push_q  <= 1'b0;
            data_q       <= '0;
            flush_done_q <= 1'b0;
            credits_q    <= FULL_CREDITS;
            hp_only_q    <= 1'b0;
            credit_err_q <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            fifo_push_q  <= fifo_push_d;
            data_q       <= data_d;
            flush_done_q <= flush_done_d;
            credits_q    <= credits_d;
            hp_only_q    <= hp_only_d;
            credit_err_q <= credit_err_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign ack          = ack_q;
    assign fifo_push    = fifo_push_q;
    assign fifo_data_in = data_q;
    assign flush_done   = flush_done_q;
    assign credits      = credits_q;
    assign hp_only      = hp_only_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_fifo_push_scheduler.sv
// Scoreboard bench for fifo_push_scheduler: directed phases queue expected grants,
// a negedge monitor pops and compares every push presented by the DUT.
module tb_fifo_push_scheduler;
    import fifo_pkg::*;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    word_t [NREQ-1:0]    req_data;
    logic [NREQ-1:0]     ack;
    logic                fifo_push;
    word_t               fifo_data_in;
    logic                fifo_pop = 1'b0;
    logic                fifo_full;
    logic                fifo_empty;
    logic                flush = 1'b0;
    logic                flush_done;
    logic [4:0]          credits;
    logic                hp_only;
    logic                credit_err;

    int                  occ;
    logic                force_nonempty = 1'b0;
    bit                  mon_en = 1'b0;
    int                  n_checks = 0;
    int                  n_pass = 0;

    typedef struct {
        int    idx;
        word_t data;
        logic  hp;
        int    cr;
    } exp_t;
    exp_t sb[$];

    fifo_push_scheduler #(
        .NUM_REQ  (NREQ),
        .DEPTH    (16),
        .AF_LEVEL (12),
        .HP_MASK  (4'b0001)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_push    (fifo_push),
        .fifo_data_in (fifo_data_in),
        .fifo_pop     (fifo_pop),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .flush        (flush),
        .flush_done   (flush_done),
        .credits      (credits),
        .hp_only      (hp_only),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    // Simple FIFO occupancy model standing in for the real FIFO flags.
    always @(posedge clk) begin
        if (reset) occ <= 0;
        else occ <= occ + (fifo_push ? 1 : 0) - ((fifo_pop && occ > 0) ? 1 : 0);
    end
    assign fifo_full  = (occ >= 16);
    assign fifo_empty = force_nonempty ? 1'b0 : (occ == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input word_t base);
        for (int i = 0; i < NREQ; i++) req_data[i] = base + word_t'(i);
    endtask

    task automatic expect_grant(input int idx, input word_t base, input logic hp, input int cr);
        exp_t e;
        e.idx  = idx;
        e.data = base + word_t'(idx);
        e.hp   = hp;
        e.cr   = cr;
        sb.push_back(e);
    endtask

    // 16 grants from an empty FIFO with all four requesting and no pops:
    // round-robin for the first 12, then only requester 0 every other cycle.
    task automatic fill16(input int start, input word_t base);
        for (int k = 1; k <= 16; k++) begin
            expect_grant((k <= 12) ? ((start + k - 1) % NREQ) : 0, base, (k >= 12), 16 - k);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            check("ack_iff_push", 32'((ack != '0) == fifo_push), 32'd1);
            if (fifo_push) begin
                check("push_on_full", 32'(fifo_full && !fifo_pop), 32'd0);
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("grant_ack", 32'(ack), 32'(1 << e.idx));
                    check("grant_data", 32'(fifo_data_in), 32'(e.data));
                    check("grant_hp_only", 32'(hp_only), 32'(e.hp));
                    check("grant_credits", 32'(credits), 32'(e.cr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '1;
        set_data(8'hA0);
        fill16(0, 8'hA0);
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_credits", 32'(credits), 32'd16);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_push", 32'(fifo_push), 32'd0);
        check("rst_hp_only", 32'(hp_only), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_data", 32'(fifo_data_in), 32'd0);

        // Fill to full: no further push once credits hit zero.
        repeat (40) tick();
        check("full_credits", 32'(credits), 32'd0);
        check("full_hp_only", 32'(hp_only), 32'd1);
        check("full_push_idle", 32'(fifo_push), 32'd0);
        check("full_credit_err", 32'(credit_err), 32'd0);
        check("full_sb_drained", 32'(sb.size()), 32'd0);

        // One pop frees one slot; rr search from 1 lands on the only HP requester.
        expect_grant(0, 8'hA0, 1'b1, 0);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        check("pop_credit", 32'(credits), 32'd1);
        repeat (4) tick();
        check("pop_regrant_credits", 32'(credits), 32'd0);
        check("pop_regrant_sb", 32'(sb.size()), 32'd0);

        // Drain to 5 words, then flush and drain the rest.
        req      = '0;
        fifo_pop = 1'b1;
        repeat (11) tick();
        fifo_pop = 1'b0;
        check("pre_flush_credits", 32'(credits), 32'd11);
        check("pre_flush_hp_only", 32'(hp_only), 32'd0);
        set_data(8'hC0);
        fill16(1, 8'hC0);
        flush = 1'b1;
        req   = '1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush_hold_credits", 32'(credits), 32'd11);
        check("flush_hold_push", 32'(fifo_push), 32'd0);
        fifo_pop = 1'b1;
        repeat (5) tick();
        fifo_pop = 1'b0;
        check("drain_credits", 32'(credits), 32'd16);
        check("drain_flush_done_early", 32'(flush_done), 32'd0);
        tick();
        check("flush_done_pulse", 32'(flush_done), 32'd1);
        check("flush_done_no_push", 32'(fifo_push), 32'd0);
        tick();
        check("resume_push", 32'(fifo_push), 32'd1);
        check("resume_ack", 32'(ack), 32'b0010);
        check("flush_done_one_cycle", 32'(flush_done), 32'd0);
        repeat (40) tick();
        check("refill_credits", 32'(credits), 32'd0);
        check("refill_sb_drained", 32'(sb.size()), 32'd0);

        // Fresh start, then an illegal pop at full credits sets the sticky error.
        req   = '0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        force_nonempty = 1'b1;
        fifo_pop       = 1'b1;
        tick();
        force_nonempty = 1'b0;
        fifo_pop       = 1'b0;
        check("err_set", 32'(credit_err), 32'd1);
        check("err_credits_clamped", 32'(credits), 32'd16);
        set_data(8'h50);
        expect_grant(0, 8'h50, 1'b0, 15);
        expect_grant(0, 8'h50, 1'b0, 14);
        expect_grant(0, 8'h50, 1'b0, 13);
        req = 4'b0001;
        repeat (5) tick();
        req = '0;
        repeat (3) tick();
        check("err_sticky", 32'(credit_err), 32'd1);
        check("err_traffic_credits", 32'(credits), 32'd13);
        check("err_traffic_sb", 32'(sb.size()), 32'd0);

        // Reset at an edge that would otherwise grant: grant dropped, state restored.
        req   = '1;
        reset = 1'b1;
        tick();
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_push", 32'(fifo_push), 32'd0);
        check("midrst_credits", 32'(credits), 32'd16);
        check("midrst_credit_err", 32'(credit_err), 32'd0);
        check("midrst_hp_only", 32'(hp_only), 32'd0);
        req = '0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("final_credits", 32'(credits), 32'd16);
        check("final_sb", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
